xor_frame_accumulator: RTL
==========================

// Module: xor_frame_accumulator
// PURPOSE
//   Streaming, parametrised XOR reduction engine: folds a frame of WIDTH-bit words
//   (first..last beat) into one column-wise XOR word plus a parity bit and beat count.
//   Sits between a valid/ready word source and a checker/CRC-lite consumer; the
//   multi-bit, multi-cycle successor of the 2-input XOR gate cells in the library.
// PARAMETERS
//   WIDTH  8  data word width in bits (>=1)
//   CNT_W  8  beat counter width; counts saturate at 2**CNT_W-1
//   ODD    0  0 = even parity (out_parity = ^acc), 1 = odd parity (out_parity = ~^acc)
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous, active-high reset
//   in_valid     in   1        input beat valid
//   in_ready     out  1        block can accept a beat
//   in_data      in   WIDTH    input word
//   in_last      in   1        beat is last of frame
//   out_valid    out  1        frame result valid
//   out_ready    in   1        consumer accepts result
//   out_word     out  WIDTH    XOR of all words in frame
//   out_parity   out  1        ^out_word ^ ODD
//   out_count    out  CNT_W    beats in frame (saturating)
//   out_ovf      out  1        beat count saturated during frame
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0,
//     out_word=0, out_parity=ODD, out_count=0, out_ovf=0. in_ready=1 after reset.
//   - Beat accepted iff in_valid & in_ready at rising clk. in_ready = (state != DONE).
//   - FSM states IDLE, ACCUM, DONE:
//     IDLE : accept -> acc<=in_data, cnt<=1, ovf<=0; in_last ? DONE : ACCUM.
//     ACCUM: accept -> acc<=acc^in_data; cnt<=cnt+1 unless cnt==max (then hold, ovf<=1);
//            in_last ? DONE : ACCUM. No accept -> hold all state.
//     DONE : out_valid=1, in_ready=0; outputs stable until out_valid&out_ready,
//            then -> IDLE with out_valid=0 on next cycle.
//   - Outputs registered: out_word/out_parity/out_count/out_ovf driven from acc/cnt/ovf;
//     valid one cycle after the last-beat edge (latency 1 from last accept).
//   - Throughput: one beat per cycle inside a frame; one bubble cycle per frame
//     (DONE refuses input even when out_ready=1 in same cycle).
//   - in_data/in_last ignored when not accepted; in_last=1 on first beat gives a
//     single-beat frame (out_word=in_data, out_count=1).
//   - Saturation: count stops at 2**CNT_W-1, out_ovf=1; XOR continues for every beat.
//   - out_ready while out_valid=0: ignored. rst mid-frame or in DONE: frame discarded,
//     all outputs return to reset values immediately.
//   - All arithmetic unsigned, modulo widths; no X propagation from idle inputs.
// TESTING
//   1 reset: rst=1 at t0 -> out_valid=0, in_ready=1, out_word=0, out_count=0.
//   2 frame 8'hA5,8'h3C,8'hFF(last), out_ready=1 -> out_word=8'h66, out_parity=0,
//     out_count=3, out_ovf=0, out_valid high exactly one cycle.
//   3 single beat 8'h01 with in_last, ODD=1 -> out_word=8'h01, out_parity=0, count=1.
//   4 backpressure: out_ready=0 for 5 cycles after frame -> out_valid and outputs
//     stable, in_ready=0 throughout; release -> IDLE, next frame accepted next cycle.
//   5 CNT_W=2, 5-beat frame of 8'h11 -> out_word=8'h11, out_count=3, out_ovf=1.
//   6 rst asserted after 2 beats of a frame -> outputs at reset values at once;
//     new frame 8'h0F(last) after release -> out_word=8'h0F, out_count=1.

Source files
------------

// File: rtl/xor_frame_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : xor_frame_accumulator
// Purpose  : Streaming XOR reduction engine. Folds a frame of WIDTH-bit words
//            (first beat .. in_last beat) into one column-wise XOR word, a
//            parity bit and a saturating beat count, then presents the result
//            on a valid/ready output until the consumer takes it.
// Ports    : clk, rst         rising-edge clock, async active-high reset
//            in_valid/ready   input beat handshake
//            in_data, in_last input word and end-of-frame marker
//            out_valid/ready  result handshake
//            out_word         XOR of all words in the frame
//            out_parity       ^out_word, inverted when ODD=1
//            out_count        beats in frame, saturating at 2**CNT_W-1
//            out_ovf          beat count saturated during the frame
// Revision : 1.0  initial release
// ============================================================================
module xor_frame_accumulator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic             ODD_BIT = (ODD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             accept;

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode. DONE refuses input even if the result
  // is drained in the same cycle, giving one bubble per frame.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_nxt = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accumulator datapath. Only accepted beats touch acc/cnt/ovf, so idle or
  // unknown input values never reach the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc <= in_data;
        cnt <= CNT_W'(1);
        ovf <= 1'b0;
      end else begin
        acc <= acc ^ in_data;
        // Count holds at its maximum; XOR folding carries on regardless.
        if (cnt == CNT_MAX) begin
          ovf <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Result outputs come straight from the accumulator flops, so they are
  // stable for the whole DONE period and valid one cycle after the last beat.
  assign out_word   = acc;
  assign out_parity = (^acc) ^ ODD_BIT;
  assign out_count  = cnt;
  assign out_ovf    = ovf;

endmodule
`default_nettype wire
